// File: rtl/dct_pkg.sv
// Shared DCT constants, coefficient vector type and bank-pointer encoding.
package dct_pkg;

    localparam int unsigned DCT_N      = 8;
    localparam int unsigned DCT_COEF_W = 12;

    typedef logic signed [DCT_COEF_W-1:0] dct_coef_t;
    typedef dct_coef_t [DCT_N-1:0]        dct_vec_t;

    typedef enum logic {
        BANK0 = 1'b0,
        BANK1 = 1'b1
    } dct_bank_e;

    function automatic dct_bank_e dct_other_bank(input dct_bank_e b);
        return (b == BANK0) ? BANK1 : BANK0;
    endfunction

endpackage

// File: rtl/dct_tp_bank.sv
// One NxN coefficient bank: column-wide write port, combinational row-wide read port.
module dct_tp_bank
    import dct_pkg::*;
#(
    parameter int unsigned DATA_W = DCT_COEF_W,
    parameter int unsigned N      = DCT_N
) (
    input  logic                          clk,
    input  logic                          wr_en,
    input  logic [$clog2(N)-1:0]          wr_col,
    input  logic [N-1:0][DATA_W-1:0]      wr_data,
    input  logic [$clog2(N)-1:0]          rd_row,
    output logic [N-1:0][DATA_W-1:0]      rd_data
);

    // Indexed [row][col]; contents are deliberately left unreset.
    logic [N-1:0][N-1:0][DATA_W-1:0] mem_q;
    logic [N-1:0][N-1:0][DATA_W-1:0] mem_d;

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            for (int unsigned r = 0; r < N; r++) begin
                mem_d[r][wr_col] = wr_data[r];
            end
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rd_data = mem_q[rd_row];

endmodule

// File: rtl/dct_transpose_buf.sv
// Ping-pong 8x8 transpose buffer: column vectors in, row vectors out with
// valid/ready on the output and sticky drop reporting on the input.
module dct_transpose_buf
    import dct_pkg::*;
#(
    parameter int unsigned DATA_W = DCT_COEF_W,
    parameter int unsigned N      = DCT_N
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_valid,
    input  logic signed [DATA_W-1:0] i_data0,
    input  logic signed [DATA_W-1:0] i_data1,
    input  logic signed [DATA_W-1:0] i_data2,
    input  logic signed [DATA_W-1:0] i_data3,
    input  logic signed [DATA_W-1:0] i_data4,
    input  logic signed [DATA_W-1:0] i_data5,
    input  logic signed [DATA_W-1:0] i_data6,
    input  logic signed [DATA_W-1:0] i_data7,
    output logic                     o_in_ready,
    output logic                     o_ovf,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic signed [DATA_W-1:0] o_data0,
    output logic signed [DATA_W-1:0] o_data1,
    output logic signed [DATA_W-1:0] o_data2,
    output logic signed [DATA_W-1:0] o_data3,
    output logic signed [DATA_W-1:0] o_data4,
    output logic signed [DATA_W-1:0] o_data5,
    output logic signed [DATA_W-1:0] o_data6,
    output logic signed [DATA_W-1:0] o_data7,
    output logic                     o_last
);

    localparam int unsigned IW       = $clog2(N);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    logic [1:0]      full_q,    full_d;
    dct_bank_e       wr_bank_q, wr_bank_d;
    dct_bank_e       rd_bank_q, rd_bank_d;
    logic [IW-1:0]   wr_cnt_q,  wr_cnt_d;
    logic [IW-1:0]   rd_cnt_q,  rd_cnt_d;
    logic            ovf_q,     ovf_d;

    logic                     wr_sel;
    logic                     rd_sel;
    logic                     accept;
    logic                     rd_xfer;
    logic [1:0]               wr_en;
    logic [N-1:0][DATA_W-1:0] in_vec;
    logic [N-1:0][DATA_W-1:0] out_vec;
    logic [N-1:0][DATA_W-1:0] bank_rd [2];

    assign in_vec = {i_data7, i_data6, i_data5, i_data4,
                     i_data3, i_data2, i_data1, i_data0};

    assign wr_sel     = (wr_bank_q == BANK1);
    assign rd_sel     = (rd_bank_q == BANK1);
    assign o_in_ready = ~full_q[wr_sel];
    assign o_valid    = full_q[rd_sel];
    assign o_last     = o_valid & (rd_cnt_q == LAST_IDX);
    assign o_ovf      = ovf_q;
    assign accept     = i_valid & o_in_ready;
    assign rd_xfer    = o_valid & i_ready;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        dct_tp_bank #(
            .DATA_W (DATA_W),
            .N      (N)
        ) u_bank (
            .clk     (i_clk),
            .wr_en   (wr_en[b]),
            .wr_col  (wr_cnt_q),
            .wr_data (in_vec),
            .rd_row  (rd_cnt_q),
            .rd_data (bank_rd[b])
        );
    end

    always_comb begin
        wr_en = '0;
        if (accept) begin
            wr_en[wr_sel] = 1'b1;
        end
    end

    always_comb begin
        out_vec = '0;
        if (o_valid) begin
            out_vec = rd_sel ? bank_rd[1] : bank_rd[0];
        end
    end

    // Writer and reader always own different banks, so both full bits may
    // change in the same cycle without conflict.
    always_comb begin
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        ovf_d     = ovf_q | (i_valid & ~o_in_ready);

        if (accept) begin
            if (wr_cnt_q == LAST_IDX) begin
                full_d[wr_sel] = 1'b1;
                wr_bank_d      = dct_other_bank(wr_bank_q);
                wr_cnt_d       = '0;
            end else begin
                wr_cnt_d = wr_cnt_q + 1'b1;
            end
        end

        if (rd_xfer) begin
            if (rd_cnt_q == LAST_IDX) begin
                full_d[rd_sel] = 1'b0;
                rd_bank_d      = dct_other_bank(rd_bank_q);
                rd_cnt_d       = '0;
            end else begin
                rd_cnt_d = rd_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            full_q    <= '0;
            wr_bank_q <= BANK0;
            rd_bank_q <= BANK0;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            ovf_q     <= 1'b0;
        end else begin
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            ovf_q     <= ovf_d;
        end
    end

    assign o_data0 = out_vec[0];
    assign o_data1 = out_vec[1];
    assign o_data2 = out_vec[2];
    assign o_data3 = out_vec[3];
    assign o_data4 = out_vec[4];
    assign o_data5 = out_vec[5];
    assign o_data6 = out_vec[6];
    assign o_data7 = out_vec[7];

endmodule

// File: tb/tb_dct_transpose_buf.sv
// Directed bench for dct_transpose_buf: expected rows are the bench's own
// transpose of the columns it chose to push, checked as they are handed off.
module tb_dct_transpose_buf;

    localparam int DW = 12;

    typedef int vec_t [8];
    typedef struct {
        int d [8];
        bit last;
    } row_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n;
    logic                 i_valid;
    logic                 i_ready;
    logic signed [DW-1:0] id [8];
    logic                 o_in_ready;
    logic                 o_ovf;
    logic                 o_valid;
    logic                 o_last;
    logic signed [DW-1:0] od [8];

    int   n_checks  = 0;
    int   n_errors  = 0;
    int   rows_seen = 0;
    row_t exp_q [$];
    vec_t cols [8];
    int   wcnt = 0;

    dct_transpose_buf #(
        .DATA_W (DW),
        .N      (8)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_valid    (i_valid),
        .i_data0    (id[0]),
        .i_data1    (id[1]),
        .i_data2    (id[2]),
        .i_data3    (id[3]),
        .i_data4    (id[4]),
        .i_data5    (id[5]),
        .i_data6    (id[6]),
        .i_data7    (id[7]),
        .o_in_ready (o_in_ready),
        .o_ovf      (o_ovf),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_data0    (od[0]),
        .o_data1    (od[1]),
        .o_data2    (od[2]),
        .o_data3    (od[3]),
        .o_data4    (od[4]),
        .o_data5    (od[5]),
        .o_data6    (od[6]),
        .o_data7    (od[7]),
        .o_last     (o_last)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic vec_t mkcol(input int blk, input int k);
        vec_t v;
        for (int r = 0; r < 8; r++) v[r] = blk * 64 + 8 * k + r;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one column for one cycle; acc is whether the plan says it fits.
    task automatic send(input vec_t v, input bit acc);
        row_t r;
        i_valid = 1'b1;
        for (int c = 0; c < 8; c++) id[c] = v[c];
        check("in_ready", o_in_ready, acc);
        step();
        i_valid = 1'b0;
        if (acc) begin
            cols[wcnt] = v;
            wcnt++;
            if (wcnt == 8) begin
                for (int j = 0; j < 8; j++) begin
                    for (int c = 0; c < 8; c++) r.d[c] = cols[c][j];
                    r.last = (j == 7);
                    exp_q.push_back(r);
                end
                wcnt = 0;
            end
        end
    endtask

    task automatic drain(input int budget, input bit toggle);
        int i;
        bit pat [4];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        i = 0;
        i_valid = 1'b0;
        while (exp_q.size() != 0 && i < budget) begin
            i_ready = toggle ? pat[i % 4] : 1'b1;
            step();
            i++;
        end
        i_ready = 1'b1;
        check("drain_done", exp_q.size(), 0);
        check("drain_idle_valid", o_valid, 0);
    endtask

    // Output monitor: handoff checks against the queue and stall stability.
    logic signed [DW-1:0] held [8];
    bit   stalled = 1'b0;
    row_t e;

    always @(negedge clk) begin
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("stall_valid", o_valid, 1);
                for (int c = 0; c < 8; c++)
                    check($sformatf("stall_c%0d", c), od[c], held[c]);
            end
            if (o_valid && i_ready) begin
                check("row_expected", (exp_q.size() > 0) ? 1 : 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    for (int c = 0; c < 8; c++)
                        check($sformatf("row%0d_c%0d", rows_seen, c), od[c], e.d[c]);
                    check($sformatf("row%0d_last", rows_seen), o_last, e.last);
                end
                rows_seen++;
            end
            stalled = o_valid && !i_ready;
            for (int c = 0; c < 8; c++) held[c] = od[c];
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: no finish, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   base;
        vec_t v;
        bit   pat [4];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};

        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        for (int c = 0; c < 8; c++) id[c] = '0;
        #12;
        check("rst_valid", o_valid, 0);
        check("rst_last", o_last, 0);
        check("rst_in_ready", o_in_ready, 1);
        check("rst_ovf", o_ovf, 0);
        check("rst_data0", od[0], 0);
        check("rst_data7", od[7], 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();

        // Single block; row j element c = 8*c+j.
        for (int k = 0; k < 8; k++) begin
            send(mkcol(0, k), 1'b1);
            if (k == 6) check("t1_valid_before", o_valid, 0);
        end
        check("t1_valid_after", o_valid, 1);
        check("t1_row0_c1", od[1], 8);
        check("t1_last_row0", o_last, 0);
        drain(20, 1'b0);
        check("t1_ovf", o_ovf, 0);

        // Three blocks back-to-back: rows must flow without a gap.
        base = rows_seen;
        for (int k = 0; k < 24; k++) send(mkcol(1 + k / 8, k % 8), 1'b1);
        check("t2_rows_during", rows_seen - base, 16);
        for (int k = 0; k < 8; k++) step();
        check("t2_rows_total", rows_seen - base, 24);
        check("t2_queue_empty", exp_q.size(), 0);
        check("t2_ovf", o_ovf, 0);

        // Full-scale alternating columns.
        for (int k = 0; k < 8; k++) begin
            for (int r = 0; r < 8; r++) v[r] = (k % 2 == 0) ? -2048 : 2047;
            send(v, 1'b1);
        end
        check("t4_row0_c0", od[0], -2048);
        check("t4_row0_c1", od[1], 2047);
        drain(20, 1'b0);

        // Stalling drain while the next block is written.
        base = rows_seen;
        for (int k = 0; k < 16; k++) begin
            i_ready = pat[k % 4];
            send(mkcol(5 + k / 8, k % 8), 1'b1);
        end
        drain(100, 1'b1);
        check("t6_rows", rows_seen - base, 16);

        // Both banks filled with no reader; 17th vector dropped.
        base = rows_seen;
        i_ready = 1'b0;
        for (int k = 0; k < 16; k++) send(mkcol(10 + k / 8, k % 8), 1'b1);
        check("t3_ovf_before", o_ovf, 0);
        send(mkcol(12, 0), 1'b0);
        check("t3_ovf_after", o_ovf, 1);
        step();
        check("t3_ovf_sticky", o_ovf, 1);
        drain(60, 1'b0);
        check("t3_rows", rows_seen - base, 16);
        check("t3_ovf_held", o_ovf, 1);

        // Reset with one full bank and a partial block pending.
        i_ready = 1'b0;
        for (int k = 0; k < 13; k++) send(mkcol(14 + k / 8, k % 8), 1'b1);
        check("t5_valid_pre", o_valid, 1);
        rst_n = 1'b0;
        #1;
        check("t5_valid", o_valid, 0);
        check("t5_last", o_last, 0);
        check("t5_in_ready", o_in_ready, 1);
        check("t5_ovf", o_ovf, 0);
        for (int c = 0; c < 8; c++) check($sformatf("t5_data%0d", c), od[c], 0);
        exp_q.delete();
        wcnt = 0;
        step();
        rst_n   = 1'b1;
        i_ready = 1'b1;
        base    = rows_seen;
        for (int k = 0; k < 8; k++) send(mkcol(16, k), 1'b1);
        drain(20, 1'b0);
        check("t5_rows", rows_seen - base, 8);
        check("t5_ovf_after", o_ovf, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
